// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU with iterative signed multiply.
// Define SEQ_ALU_DIV_EN to add the restoring signed divider (DIV/MOD).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         Control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               carry,
  output logic               overflow,
  output logic               negative,
  output logic               zero,
  output logic               busy
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_SUM  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NEGB = 4'd2;
  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NEGA = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_MOD  = 4'd11;
`endif

  typedef enum logic [1:0] {
    IDLE, EXEC, ITER, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [3:0]        op_q;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     acc, mcand;
  logic [WIDTH-1:0]  shreg;
  logic [W2-1:0]     sa, sb, res_n;
  logic              c_n, v_n;
  logic              accept, fin;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic is_iter(input logic [3:0] o);
`ifdef SEQ_ALU_DIV_EN
    return o == OP_MULT || o == OP_DIV || o == OP_MOD;
`else
    return o == OP_MULT;
`endif
  endfunction

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] rem, mb, rem_sh, q_s, r_s;
  assign mb     = mag(b_q);
  assign rem_sh = {rem[WIDTH-2:0], shreg[WIDTH-1]};
  assign q_s    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -shreg : shreg;
  assign r_s    = a_q[WIDTH-1] ? -rem : rem;
`endif

  assign in_ready  = !rst && (state == IDLE ||
                     (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign busy      = state == EXEC || state == ITER;
  assign fin       = state == EXEC ||
                     (state == ITER && cnt == CMAX);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = is_iter(Control) ? ITER : EXEC;
        else if (state == DONE && out_ready)
          state_nxt = IDLE;
      end
      EXEC: state_nxt = DONE;
      ITER: if (cnt == CMAX) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sa = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign sb = {{WIDTH{b_q[WIDTH-1]}}, b_q};

  // W-bit overflow shows as bit WIDTH disagreeing with bit WIDTH-1
  always_comb begin
    res_n = '0;
    c_n   = 1'b0;
    v_n   = 1'b0;
    unique case (op_q)
      OP_SUM: begin
        res_n = sa + sb;
        c_n   = (a_q[WIDTH-1] & b_q[WIDTH-1]) |
                ((a_q[WIDTH-1] | b_q[WIDTH-1]) &
                 ~res_n[WIDTH-1]);
        v_n   = res_n[WIDTH] ^ res_n[WIDTH-1];
      end
      OP_SUB: begin
        res_n = sa - sb;
        c_n   = a_q < b_q;
        v_n   = res_n[WIDTH] ^ res_n[WIDTH-1];
      end
      OP_NEGA: begin
        res_n = -sa;
        v_n   = a_q == MINV;
      end
      OP_NEGB: begin
        res_n = -sb;
        v_n   = b_q == MINV;
      end
      OP_AND: res_n = sa & sb;
      OP_OR:  res_n = sa | sb;
      OP_XOR: res_n = sa ^ sb;
      OP_SHL: res_n = sa << b_q;
      OP_SHR: res_n = $signed(sa) >>> b_q;
      OP_MULT: begin
        res_n = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc : acc;
        v_n   = !(&res_n[W2-1:WIDTH-1] ||
                  ~|res_n[W2-1:WIDTH-1]);
      end
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_MOD: begin
        if (b_q == '0) begin
          res_n = (op_q == OP_DIV) ? {a_q, {WIDTH{1'b1}}} : sa;
          c_n   = 1'b1;
          v_n   = 1'b1;
        end else begin
          res_n = (op_q == OP_DIV) ? {r_s, q_s}
                : {{WIDTH{r_s[WIDTH-1]}}, r_s};
          v_n   = a_q == MINV && b_q == '1;
        end
      end
`endif
      default: res_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      shreg    <= '0;
`ifdef SEQ_ALU_DIV_EN
      rem      <= '0;
`endif
      Result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= Control;
        cnt   <= '0;
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, mag(A)};
        shreg <= (Control == OP_MULT) ? mag(B) : mag(A);
`ifdef SEQ_ALU_DIV_EN
        rem   <= '0;
`endif
      end else if (state == ITER && cnt != CMAX) begin
        cnt <= cnt + 1'b1;
        if (op_q == OP_MULT) begin
          if (shreg[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          shreg <= shreg >> 1;
        end
`ifdef SEQ_ALU_DIV_EN
        else if (rem_sh >= mb) begin
          rem   <= rem_sh - mb;
          shreg <= {shreg[WIDTH-2:0], 1'b1};
        end else begin
          rem   <= rem_sh;
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
`endif
      end
      if (fin) begin
        Result   <= res_n;
        carry    <= c_n;
        overflow <= v_n;
        negative <= res_n[W2-1];
        zero     <= res_n == '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu (WIDTH=8)
// against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   A, B;
  logic [3:0]     Control;
  logic [2*W-1:0] Result;
  logic           carry, overflow, negative, zero, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_res;
  logic [3:0]  last_flags;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Control(Control),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .carry(carry), .overflow(overflow),
    .negative(negative), .zero(zero), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic iter_op(input logic [3:0] o);
`ifdef SEQ_ALU_DIV_EN
    return o == 4'd3 || o == 4'd10 || o == 4'd11;
`else
    return o == 4'd3;
`endif
  endfunction

  // Flags packed as {carry, overflow, negative, zero}
  function automatic void model(input logic [3:0] op,
                                input logic [7:0] a,
                                input logic [7:0] b,
                                output logic [15:0] res,
                                output logic [3:0] flg,
                                output int lat);
    longint sa, sb, r, q;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; c = 0; v = 0;
    lat = iter_op(op) ? W + 2 : 2;
    case (op)
      4'd0: begin
        r = sa + sb;
        c = (int'(a) + int'(b)) > 255;
        v = r > 127 || r < -128;
      end
      4'd1: begin
        r = sa - sb;
        c = a < b;
        v = r > 127 || r < -128;
      end
      4'd2: begin r = -sb; v = r > 127; end
      4'd3: begin
        r = sa * sb;
        v = r > 127 || r < -128;
      end
      4'd4: r = sa & sb;
      4'd5: r = sa | sb;
      4'd6: begin r = -sa; v = r > 127; end
      4'd7: r = sa ^ sb;
      4'd8: r = (b >= 16) ? 0 : sa << b;
      4'd9: r = (b >= 16) ? ((sa < 0) ? -1 : 0) : sa >>> b;
`ifdef SEQ_ALU_DIV_EN
      4'd10, 4'd11: begin
        if (sb == 0) begin
          q = -1; r = sa; c = 1; v = 1;
        end else begin
          q = sa / sb; r = sa % sb; v = q > 127;
        end
        if (op == 4'd10) r = (r & 255) * 256 + (q & 255);
      end
`endif
      default: r = 0;
    endcase
    res = 16'(r);
    flg = {c, v, res[15], res == 16'h0};
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b);
    logic [15:0] er;
    logic [3:0] ef;
    int el, n;
    model(op, a, b, er, ef, el);
    A = a; B = b; Control = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    step();
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    Control = 4'($urandom);
    n = 1;
    while (!out_valid && n < 100) begin step(); n++; end
    chk($sformatf("lat op%0d", op), 32'(n), 32'(el));
    chk($sformatf("res op%0d a%0h b%0h", op, a, b),
        32'(Result), 32'(er));
    chk($sformatf("flags op%0d a%0h b%0h", op, a, b),
        32'({carry, overflow, negative, zero}), 32'(ef));
    last_res = Result;
    last_flags = {carry, overflow, negative, zero};
    step();
  endtask

  initial begin
    logic [15:0] er;
    logic [3:0] ef, o;
    int el, n, sent, got, cyc, hits;
    logic acc_now, xf_now;
    logic [15:0] qr[$];
    logic [3:0] qf[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Control = '0;
    step(); step();
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", 32'(Result), 32'd0);
    chk("rst flags",
        32'({carry, overflow, negative, zero}), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 32'(in_ready), 32'd1);

    run_op(4'd0, 8'h7F, 8'h01);
    chk("plan sum", 32'(last_res), 32'h0080);
    chk("plan sum flags", 32'(last_flags), 32'b0100);
    run_op(4'd1, 8'h00, 8'h01);
    chk("plan sub", 32'(last_res), 32'hFFFF);
    chk("plan sub flags", 32'(last_flags), 32'b1010);
    run_op(4'd7, 8'h55, 8'h55);
    chk("plan xor", 32'(last_res), 32'h0000);
    chk("plan xor flags", 32'(last_flags), 32'b0001);
    run_op(4'd3, 8'hF6, 8'h07);
    chk("plan mul", 32'(last_res), 32'hFFBA);
    chk("plan mul flags", 32'(last_flags), 32'b0010);
    run_op(4'd3, 8'h80, 8'h80);
    chk("plan mul ovf", 32'(last_res), 32'h4000);
    chk("plan mul ovf flags", 32'(last_flags), 32'b0100);
    run_op(4'd6, 8'h80, 8'h00);
    chk("nega min", 32'(last_res), 32'h0080);
    run_op(4'd8, 8'h01, 8'd16);
    chk("shl big", 32'(last_res), 32'h0000);
    run_op(4'd9, 8'h80, 8'd200);
    chk("shr big", 32'(last_res), 32'hFFFF);
    run_op(4'd13, 8'h12, 8'h34);
    chk("illegal", 32'(last_res), 32'h0000);
`ifdef SEQ_ALU_DIV_EN
    run_op(4'd10, 8'hEC, 8'h03);
    chk("plan div", 32'(last_res), 32'hFEFA);
    run_op(4'd10, 8'h05, 8'h00);
    chk("plan div0", 32'(last_res), 32'h05FF);
    chk("plan div0 flags", 32'(last_flags), 32'b1100);
    run_op(4'd11, 8'h80, 8'hFF);
`else
    run_op(4'd10, 8'hEC, 8'h03);
    chk("div off", 32'(last_res), 32'h0000);
    chk("div off flags", 32'(last_flags), 32'b0001);
`endif

    // Backpressure: result held while consumer stalls
    model(4'd0, 8'h90, 8'hA5, er, ef, el);
    out_ready = 1'b0;
    A = 8'h90; B = 8'hA5; Control = 4'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp result", 32'(Result), 32'(er));
      chk("bp flags",
          32'({carry, overflow, negative, zero}), 32'(ef));
      step();
    end
    model(4'd1, 8'h40, 8'hC0, er, ef, el);
    out_ready = 1'b1;
    A = 8'h40; B = 8'hC0; Control = 4'd1; in_valid = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b valid drop", 32'(out_valid), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    step();
    chk("b2b valid", 32'(out_valid), 32'd1);
    chk("b2b result", 32'(Result), 32'(er));
    chk("b2b flags",
        32'({carry, overflow, negative, zero}), 32'(ef));
    step();

    // Streamed simple ops with out_ready held high
    sent = 0; got = 0; cyc = 0;
    do o = 4'($urandom_range(0, 15)); while (iter_op(o));
    A = 8'($urandom); B = 8'($urandom_range(0, 20));
    Control = o; in_valid = 1'b1;
    while (got < 16 && cyc < 200) begin
      acc_now = in_valid && in_ready;
      xf_now = out_valid && out_ready;
      if (xf_now) begin
        chk("stream extra", 32'(qr.size() > 0), 32'd1);
        if (qr.size() > 0) begin
          chk("stream result", 32'(Result), 32'(qr.pop_front()));
          chk("stream flags",
              32'({carry, overflow, negative, zero}),
              32'(qf.pop_front()));
        end
        got++;
      end
      if (acc_now) begin
        model(Control, A, B, er, ef, el);
        qr.push_back(er);
        qf.push_back(ef);
        sent++;
      end
      step();
      cyc++;
      if (acc_now) begin
        if (sent < 16) begin
          do o = 4'($urandom_range(0, 15)); while (iter_op(o));
          A = 8'($urandom); B = 8'($urandom_range(0, 20));
          Control = o;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("stream count", 32'(got), 32'd16);
    chk("stream cycles", 32'(cyc), 32'd33);

    // Reset in the 4th multiply iteration aborts the op
    A = 8'hF6; B = 8'h07; Control = 4'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", 32'(Result), 32'd0);
    chk("abort flags",
        32'({carry, overflow, negative, zero}), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort idle", 32'(in_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) hits++;
    end
    chk("abort no result", 32'(hits), 32'd0);
    run_op(4'd0, 8'h02, 8'h03);
    chk("post rst sum", 32'(last_res), 32'h0005);

    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom),
             8'($urandom_range(0, 3) == 0 ?
                $urandom_range(0, 20) : $urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
